sigma_delta_dac: RTL and testbench
==================================

SIGMA_DELTA_DAC -- requirements
Module: sigma_delta_dac

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: sample code width in bits; legal range 2 to 16.
REQ-002 The block SHALL have parameter OSR, default 256: clock cycles per sample period; legal range 2 to 65536.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 en  input  1  conversion enable.
REQ-006 din  input  WIDTH  unsigned sample code.
REQ-007 din_valid  input  1  din is valid this cycle.
REQ-008 din_ready  output  1  holding register can accept a sample.
REQ-009 dac_out  output  1  registered first-order sigma-delta bitstream.
REQ-010 underrun  output  1  one-cycle pulse when a sample period starts with no new sample available.
REQ-011 busy  output  1  high while the state machine is in RUN.

Function
REQ-012 A sample SHALL transfer into the holding register on any clock edge where din_valid=1 and din_ready=1, in both IDLE and RUN.
REQ-013 din_ready SHALL equal NOT hold_full, with no combinational path from din_valid.
REQ-014 The state machine SHALL have two states: IDLE and RUN.
REQ-015 IDLE behaviour:
- acc=0, os_cnt=0, dac_out=0, busy=0.
- When en=1 and hold_full=1: load cur<=hold, clear hold_full, and go to RUN at that edge.
REQ-016 RUN behaviour, every cycle:
- sum = acc + cur, computed WIDTH+1 bits wide.
- acc <= sum[WIDTH-1:0].
- dac_out <= sum[WIDTH].
- os_cnt increments and wraps from OSR-1 to 0.
REQ-017 The accumulator SHALL NOT be cleared at sample boundaries in RUN; the residue carries across samples.
REQ-018 Sample-boundary reload, on the edge where os_cnt=OSR-1:
- If hold_full=1: cur<=hold and clear hold_full.
- Otherwise: cur is kept (the sample repeats) and underrun=1 for exactly the next cycle.
REQ-019 When a handshake and a reload happen on the same edge:
- With hold_full=1 before the edge: din_ready=0, so no handshake can occur.
- With hold_full=0 before the edge: the reload takes the underrun path, and the incoming sample sets hold_full for the next period.
REQ-020 Latency: the first bitstream bit SHALL appear on dac_out one cycle after the state becomes RUN.
REQ-021 Over any OSR-cycle period in RUN starting from acc=0 with constant cur=s, the count of dac_out ones SHALL equal floor(s*OSR/2^WIDTH).
REQ-022 If en=0 in RUN, the next edge SHALL enter IDLE: acc=0, os_cnt=0, dac_out=0; hold and hold_full are retained and cur is discarded.
REQ-023 If en=0 and en=1 occur in consecutive cycles, a RUN restart SHALL require a held sample (REQ-015); no partial period resumes.

Reset
REQ-024 Asserting rst SHALL immediately set state=IDLE and clear acc, os_cnt, cur, hold and hold_full, with dac_out=0, underrun=0, busy=0 and din_ready=1.
REQ-025 Reset asserted mid-period SHALL abort the period; no sample SHALL survive reset.
REQ-026 Reset deassertion SHALL be synchronised externally to clk; the block adds no synchroniser.

Structure
REQ-027 Package sd_dac_pkg SHALL hold:
- the state enum (IDLE, RUN);
- default constants for WIDTH and OSR;
- the counter-width function clog2(OSR).
REQ-028 Sub-module sd_dac_accum SHALL hold the accumulator register and carry output, with ports clk, rst, clr, en, cur and bit_out.
REQ-029 The top module SHALL contain the FSM, the holding register, the sample-period counter and the handshake logic.

Verification
REQ-030 With WIDTH=8 and OSR=256, push 0x80 with en=1 -> busy rises; dac_out has exactly 128 ones in the first 256 RUN cycles, alternating 0,1 from the first bit.
REQ-031 Push 0x00, then 0xFF -> period 1 has 0 ones and period 2 has 255 ones; no underrun.
REQ-032 Push one sample only -> at the second boundary underrun pulses for 1 cycle and the sample repeats; din_ready stays 1.
REQ-033 With hold full, hold din_valid=1 -> din_ready=0 until the boundary edge; the next sample is accepted on the cycle after the reload.
REQ-034 Drop en to 0 mid-period -> IDLE next edge with dac_out=0; the held sample is replayed after en=1.
REQ-035 Assert rst asynchronously mid-period -> all outputs clear without waiting for a clock edge; din_ready=1.

Source files
------------

// File: rtl/sd_dac_pkg.sv
// sd_dac_pkg: shared types and constants for the first-order sigma-delta DAC.
//   state_t        - controller states (IDLE, RUN)
//   DEFAULT_WIDTH  - default sample code width in bits
//   DEFAULT_OSR    - default clock cycles per sample period
//   clog2()        - bit width needed to count 0 .. value-1
package sd_dac_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_OSR   = 256;

    // Width of a counter that must hold 0 .. value-1 (value >= 2 gives >= 1 bit).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sd_dac_accum.sv
// sd_dac_accum: first-order sigma-delta accumulator.
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   clr     - synchronous clear of accumulator and output bit (wins over en)
//   en      - advance the accumulator by cur this cycle
//   cur     - current sample code being modulated
//   bit_out - registered carry of acc + cur (the bitstream)
module sd_dac_accum
    import sd_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] cur,
    output logic             bit_out
);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH:0]   sum_s;

    // One extra bit so the carry out of acc + cur becomes the output bit.
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, cur};
    end

    // Accumulator and bitstream register; the residue is kept between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {WIDTH{1'b0}};
            bit_out <= 1'b0;
        end else if (clr) begin
            acc_r   <= {WIDTH{1'b0}};
            bit_out <= 1'b0;
        end else if (en) begin
            acc_r   <= sum_s[WIDTH-1:0];
            bit_out <= sum_s[WIDTH];
        end else begin
            acc_r   <= acc_r;
            bit_out <= bit_out;
        end
    end

endmodule

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: sample-rate input, one-bit first-order sigma-delta output.
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset (deassertion synchronised externally)
//   en        - conversion enable
//   din       - unsigned sample code
//   din_valid - din is valid this cycle
//   din_ready - holding register is empty and can accept a sample
//   dac_out   - registered bitstream
//   underrun  - one-cycle pulse: a sample period started with no new sample
//   busy      - controller is in RUN
module sigma_delta_dac
    import sd_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OSR   = DEFAULT_OSR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dac_out,
    output logic             underrun,
    output logic             busy
);

    localparam int                CNT_W   = clog2(OSR);
    localparam logic [CNT_W-1:0]  OS_LAST = CNT_W'(OSR - 1);

    state_t           state_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic [WIDTH-1:0] cur_r;
    logic [CNT_W-1:0] os_cnt_r;
    logic             underrun_r;
    logic             busy_r;

    logic             take_s;
    logic             boundary_s;
    logic             acc_en_s;
    logic             acc_clr_s;

    // Handshake and period decode. A handshake is only possible while the
    // holding register is empty, so it never collides with a reload that
    // empties it on the same edge.
    always_comb begin
        take_s     = din_valid & ~hold_full_r;
        boundary_s = (os_cnt_r == OS_LAST);
        acc_en_s   = (state_r == RUN);
        acc_clr_s  = (state_r != RUN) | ~en;
    end

    // Controller: state, holding register, current sample, period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            cur_r       <= {WIDTH{1'b0}};
            os_cnt_r    <= {CNT_W{1'b0}};
            underrun_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    os_cnt_r <= {CNT_W{1'b0}};
                    if (en && hold_full_r) begin
                        cur_r       <= hold_r;
                        hold_full_r <= 1'b0;
                        state_r     <= RUN;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Abandon the period; the held sample stays for a restart.
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        os_cnt_r <= {CNT_W{1'b0}};
                        cur_r    <= {WIDTH{1'b0}};
                    end else if (boundary_s) begin
                        os_cnt_r <= {CNT_W{1'b0}};
                        if (hold_full_r) begin
                            cur_r       <= hold_r;
                            hold_full_r <= 1'b0;
                        end else begin
                            // Keep repeating cur and flag the missing sample.
                            underrun_r <= 1'b1;
                        end
                    end else begin
                        os_cnt_r <= os_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    os_cnt_r <= {CNT_W{1'b0}};
                    cur_r    <= {WIDTH{1'b0}};
                end
            endcase
            if (take_s) begin
                hold_r      <= din;
                hold_full_r <= 1'b1;
            end
        end
    end

    sd_dac_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr_s),
        .en      (acc_en_s),
        .cur     (cur_r),
        .bit_out (dac_out)
    );

    assign din_ready = ~hold_full_r;
    assign underrun  = underrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb_sigma_delta_dac: directed self-checking bench for sigma_delta_dac
// with WIDTH=8, OSR=256.
module tb_sigma_delta_dac;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dac_out;
    logic       underrun;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    sigma_delta_dac #(
        .WIDTH (8),
        .OSR   (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dac_out   (dac_out),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_idle(input logic [7:0] v);
        din = v; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic start_run();
        en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = 8'h00;
        @(posedge clk); #1;
        compared++; if (dac_out !== 1'b0) begin mismatched++; $display("FAIL reset_dac_out: got %b want 0", dac_out); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (underrun !== 1'b0) begin mismatched++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        compared++; if (din_ready !== 1'b1) begin mismatched++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // 0x80: alternating 0,1 from the first bit; one sample only, so each
    // boundary underruns and the sample repeats.
    task automatic test_half_scale();
        int ones;
        logic exp_bit;
        logic exp_under;
        do_reset();
        push_idle(8'h80);
        compared++; if (din_ready !== 1'b0) begin mismatched++; $display("FAIL half_hold_full: din_ready got %b want 0", din_ready); end
        start_run();
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL half_busy: got %b want 1", busy); end
        compared++; if (dac_out !== 1'b0) begin mismatched++; $display("FAIL half_entry_bit: got %b want 0", dac_out); end
        ones = 0;
        for (int e = 1; e <= 512; e++) begin
            @(posedge clk); #1;
            exp_bit   = ((e % 2) == 0);
            exp_under = (e == 256) || (e == 512);
            compared++; if (dac_out !== exp_bit) begin mismatched++; $display("FAIL half_bit[%0d]: got %b want %b", e, dac_out, exp_bit); end
            compared++; if (underrun !== exp_under) begin mismatched++; $display("FAIL half_underrun[%0d]: got %b want %b", e, underrun, exp_under); end
            compared++; if (din_ready !== 1'b1) begin mismatched++; $display("FAIL half_din_ready[%0d]: got %b want 1", e, din_ready); end
            if (e <= 256 && dac_out === 1'b1) ones++;
        end
        compared++; if (ones !== 128) begin mismatched++; $display("FAIL half_ones: got %0d want 128", ones); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL half_busy_end: got %b want 1", busy); end
        en = 1'b0;
    endtask

    // 0x00 then 0xFF back to back: 0 ones, then 255 ones, no underrun
    // until the third boundary.
    task automatic test_zero_then_full();
        int ones1;
        int ones2;
        logic exp_under;
        do_reset();
        push_idle(8'h00);
        start_run();
        din = 8'hFF; din_valid = 1'b1;
        ones1 = 0; ones2 = 0;
        for (int e = 1; e <= 512; e++) begin
            @(posedge clk); #1;
            if (e == 1) din_valid = 1'b0;
            exp_under = (e == 512);
            compared++; if (underrun !== exp_under) begin mismatched++; $display("FAIL zf_underrun[%0d]: got %b want %b", e, underrun, exp_under); end
            if (dac_out === 1'b1) begin
                if (e <= 256) ones1++; else ones2++;
            end
        end
        compared++; if (ones1 !== 0) begin mismatched++; $display("FAIL zf_ones_p1: got %0d want 0", ones1); end
        compared++; if (ones2 !== 255) begin mismatched++; $display("FAIL zf_ones_p2: got %0d want 255", ones2); end
        en = 1'b0;
    endtask

    // Held full with din_valid asserted: ready only right after each reload.
    task automatic test_back_to_back();
        int ones1;
        int ones2;
        logic exp_ready;
        do_reset();
        push_idle(8'h40);
        start_run();
        din = 8'h20; din_valid = 1'b1;
        ones1 = 0; ones2 = 0;
        for (int e = 1; e <= 512; e++) begin
            @(posedge clk); #1;
            if (e == 1) din = 8'h60;
            if (e == 257) din_valid = 1'b0;
            exp_ready = (e == 256) || (e == 512);
            compared++; if (din_ready !== exp_ready) begin mismatched++; $display("FAIL b2b_din_ready[%0d]: got %b want %b", e, din_ready, exp_ready); end
            compared++; if (underrun !== 1'b0) begin mismatched++; $display("FAIL b2b_underrun[%0d]: got %b want 0", e, underrun); end
            if (dac_out === 1'b1) begin
                if (e <= 256) ones1++; else ones2++;
            end
        end
        compared++; if (ones1 !== 64) begin mismatched++; $display("FAIL b2b_ones_p1: got %0d want 64", ones1); end
        compared++; if (ones2 !== 32) begin mismatched++; $display("FAIL b2b_ones_p2: got %0d want 32", ones2); end
        en = 1'b0;
    endtask

    // en dropped mid-period: IDLE next edge, held sample replayed on restart.
    task automatic test_enable_drop();
        logic exp_bit;
        do_reset();
        push_idle(8'h80);
        start_run();
        din = 8'h40; din_valid = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e == 1) din_valid = 1'b0;
        end
        compared++; if (dac_out !== 1'b1) begin mismatched++; $display("FAIL drop_pre_bit: got %b want 1", dac_out); end
        en = 1'b0;
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL drop_busy: got %b want 0", busy); end
        compared++; if (dac_out !== 1'b0) begin mismatched++; $display("FAIL drop_dac_out: got %b want 0", dac_out); end
        compared++; if (din_ready !== 1'b0) begin mismatched++; $display("FAIL drop_hold_kept: din_ready got %b want 0", din_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            compared++; if (busy !== 1'b0 || dac_out !== 1'b0) begin mismatched++; $display("FAIL drop_idle[%0d]: busy %b dac_out %b want 0 0", k, busy, dac_out); end
        end
        start_run();
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_busy: got %b want 1", busy); end
        compared++; if (din_ready !== 1'b1) begin mismatched++; $display("FAIL restart_din_ready: got %b want 1", din_ready); end
        compared++; if (dac_out !== 1'b0) begin mismatched++; $display("FAIL restart_entry_bit: got %b want 0", dac_out); end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_bit = ((k % 4) == 0);
            compared++; if (dac_out !== exp_bit) begin mismatched++; $display("FAIL restart_bit[%0d]: got %b want %b", k, dac_out, exp_bit); end
        end
        en = 1'b0;
    endtask

    // Asynchronous reset mid-period: outputs clear before any clock edge,
    // and no sample survives.
    task automatic test_async_reset();
        do_reset();
        push_idle(8'h80);
        start_run();
        din = 8'h40; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        compared++; if (dac_out !== 1'b1) begin mismatched++; $display("FAIL areset_pre_bit: got %b want 1", dac_out); end
        compared++; if (din_ready !== 1'b0) begin mismatched++; $display("FAIL areset_pre_ready: got %b want 0", din_ready); end
        #2;
        rst = 1'b1;
        #1;
        compared++; if (dac_out !== 1'b0) begin mismatched++; $display("FAIL areset_dac_out: got %b want 0", dac_out); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL areset_busy: got %b want 0", busy); end
        compared++; if (din_ready !== 1'b1) begin mismatched++; $display("FAIL areset_din_ready: got %b want 1", din_ready); end
        compared++; if (underrun !== 1'b0) begin mismatched++; $display("FAIL areset_underrun: got %b want 0", underrun); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            compared++; if (busy !== 1'b0 || din_ready !== 1'b1) begin mismatched++; $display("FAIL areset_no_sample[%0d]: busy %b din_ready %b want 0 1", k, busy, din_ready); end
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = 8'h00;
        test_reset();
        test_half_scale();
        test_zero_then_full();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
